// File: rtl/prsc_sched.sv
// Round-robin scheduler sharing one clock prescaler between NUM_REQ requesters.
// Optional watchdog abort in RUN is enabled by defining PRSC_SCHED_TIMEOUT_EN.
module prsc_sched #(
    parameter int NUM_REQ = 4,
    parameter int PRSC_W  = 3,
    parameter int BURST_W = 8,
    parameter int TO_W    = 12,
    localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*PRSC_W-1:0]   req_prsc_i,
    input  logic [NUM_REQ*BURST_W-1:0]  req_burst_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [NUM_REQ-1:0]          err_o,
    output logic                        prsc_en_o,
    output logic [PRSC_W-1:0]           prsc_count_o,
    input  logic                        prsc_tick_i,
    output logic                        busy_o,
    output logic [OW-1:0]               owner_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [OW-1:0]        owner_reg;
    logic [OW-1:0]        rr_ptr_reg;
    logic [PRSC_W-1:0]    prsc_count_reg;
    logic [BURST_W-1:0]   burst_reg;
    logic [BURST_W-1:0]   tick_cnt_reg;
    logic                 grant_found;
    logic [OW-1:0]        grant_idx;
    logic                 tick_last;
    logic                 err_flag;

    logic [PRSC_W-1:0]    prsc_arr  [NUM_REQ];
    logic [BURST_W-1:0]   burst_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign prsc_arr[gi]  = req_prsc_i[gi*PRSC_W +: PRSC_W];
        assign burst_arr[gi] = req_burst_i[gi*BURST_W +: BURST_W];
        // Ready is gated by reset so no grant is advertised while held in reset.
        assign req_ready_o[gi] = rstn_i && (state_reg == IDLE) && grant_found
                                 && (grant_idx == OW'(gi));
        assign done_o[gi] = (state_reg == DONE) && !err_flag && (owner_reg == OW'(gi));
`ifdef PRSC_SCHED_TIMEOUT_EN
        assign err_o[gi]  = (state_reg == DONE) && err_flag && (owner_reg == OW'(gi));
`else
        assign err_o[gi]  = 1'b0;
`endif
    end

    // Search from the rr pointer upward with wrap; first valid wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid_i[OW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = OW'(idx);
            end
        end
    end

    assign tick_last = (tick_cnt_reg == burst_reg - BURST_W'(1));

`ifdef PRSC_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] wdog_reg;
    logic [TO_W-1:0] wdog_inc;
    logic            wdog_expire;
    assign wdog_inc    = wdog_reg + TO_W'(1);
    assign wdog_expire = (state_reg == RUN) && !prsc_tick_i && (&wdog_inc);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wdog_reg <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state_reg == LOAD) begin
                wdog_reg <= '0;
                err_flag <= 1'b0;
            end else if (state_reg == RUN) begin
                wdog_reg <= prsc_tick_i ? '0 : wdog_inc;
                if (wdog_expire) err_flag <= 1'b1;
            end
        end
    end
`else
    assign err_flag = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant_found) state_next = LOAD;
            LOAD: state_next = (burst_reg == '0) ? DONE : RUN;
            RUN: begin
                if (prsc_tick_i && tick_last) state_next = DONE;
`ifdef PRSC_SCHED_TIMEOUT_EN
                else if (wdog_expire) state_next = DONE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prsc_en_o = 1'b0;
        busy_o    = 1'b1;
        case (state_reg)
            IDLE:    busy_o    = 1'b0;
            RUN:     prsc_en_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_reg      <= '0;
            rr_ptr_reg     <= '0;
            prsc_count_reg <= '0;
            burst_reg      <= '0;
            tick_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: if (grant_found) begin
                    owner_reg      <= grant_idx;
                    prsc_count_reg <= prsc_arr[grant_idx];
                    burst_reg      <= burst_arr[grant_idx];
                end
                LOAD: tick_cnt_reg <= '0;
                RUN: begin
                    if (prsc_tick_i) begin
                        tick_cnt_reg <= tick_last ? '0 : tick_cnt_reg + BURST_W'(1);
                    end
`ifdef PRSC_SCHED_TIMEOUT_EN
                    else if (wdog_expire) tick_cnt_reg <= '0;
`endif
                end
                DONE: rr_ptr_reg <= (owner_reg == OW'(NUM_REQ - 1)) ? '0 : owner_reg + OW'(1);
                default: ;
            endcase
        end
    end

    assign owner_o      = owner_reg;
    assign prsc_count_o = prsc_count_reg;

endmodule

// File: tb/tb_prsc_sched.sv
// Scoreboard bench for prsc_sched: grants are predicted by a bench round-robin
// model, and each completion is popped and checked against the expected burst.
module tb_prsc_sched;
    localparam int NUM_REQ = 4;
    localparam int PRSC_W  = 3;
    localparam int BURST_W = 8;
`ifdef PRSC_SCHED_TIMEOUT_EN
    localparam int TO_W    = 4;
`else
    localparam int TO_W    = 12;
`endif
    localparam int OW      = 2;

    logic                        clk_i = 1'b0;
    logic                        rstn_i = 1'b0;
    logic [NUM_REQ-1:0]          req_valid_i = '0;
    logic [NUM_REQ*PRSC_W-1:0]   req_prsc_i;
    logic [NUM_REQ*BURST_W-1:0]  req_burst_i;
    logic [NUM_REQ-1:0]          req_ready_o, done_o, err_o;
    logic                        prsc_en_o, busy_o, prsc_tick_i;
    logic [PRSC_W-1:0]           prsc_count_o;
    logic [OW-1:0]               owner_o;

    int prsc_tb  [NUM_REQ];
    int burst_tb [NUM_REQ];
    bit tick_block = 1'b0;

    prsc_sched #(.NUM_REQ(NUM_REQ), .PRSC_W(PRSC_W), .BURST_W(BURST_W), .TO_W(TO_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i),
        .req_prsc_i(req_prsc_i), .req_burst_i(req_burst_i),
        .req_ready_o(req_ready_o), .done_o(done_o), .err_o(err_o),
        .prsc_en_o(prsc_en_o), .prsc_count_o(prsc_count_o), .prsc_tick_i(prsc_tick_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        req_prsc_i  = '0;
        req_burst_i = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_prsc_i[i*PRSC_W +: PRSC_W]    = PRSC_W'(prsc_tb[i]);
            req_burst_i[i*BURST_W +: BURST_W] = BURST_W'(burst_tb[i]);
        end
    end

    // Prescaler model: restarts while disabled, ticks every prsc_count+1 enabled clocks.
    logic [PRSC_W-1:0] pc_reg;
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i || !prsc_en_o)     pc_reg <= '0;
        else if (pc_reg == prsc_count_o) pc_reg <= '0;
        else                           pc_reg <= pc_reg + 1'b1;
    end
    assign prsc_tick_i = prsc_en_o && (pc_reg == prsc_count_o) && !tick_block;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int idx;
        int burst;
        int prsc;
        int gcyc;
        bit exp_err;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   cyc = 0, ticks = 0, last_tick_cyc = 0, n_done = 0, model_rr = 0;
    bit   en_seen = 1'b0;
    logic [PRSC_W-1:0] prev_cnt = '0;

    always @(negedge clk_i) begin
        exp_t e;
        int   pick;
        cyc++;
        if (!rstn_i) begin
            sb_q.delete();
            model_rr = 0;
            ticks    = 0;
            en_seen  = 1'b0;
            prev_cnt = '0;
        end else begin
            if (prsc_tick_i && prsc_en_o) begin
                ticks++;
                last_tick_cyc = cyc;
            end
            if (prsc_en_o) en_seen = 1'b1;
            if (prsc_count_o != prev_cnt)
                check("cnt_only_in_load", 32'(sb_q.size() > 0 && cyc == sb_q[0].gcyc + 1), 1);
            prev_cnt = prsc_count_o;
            if (sb_q.size() > 0 && cyc == sb_q[0].gcyc + 1) begin
                check("load_count", 32'(prsc_count_o), 32'(sb_q[0].prsc));
                check("load_en_low", 32'(prsc_en_o), 0);
            end
            if (sb_q.size() > 0 && cyc == sb_q[0].gcyc + 2 && sb_q[0].burst != 0)
                check("en_latency", 32'(prsc_en_o), 1);
            if (done_o != '0 || err_o != '0) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 32'({done_o, err_o}), 0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.exp_err) begin
                        check("err_onehot", 32'(err_o), 32'(1) << e.idx);
                        check("err_no_done", 32'(done_o), 0);
                        check("err_latency", 32'(cyc - e.gcyc), 17);
                    end else begin
                        check("done_onehot", 32'(done_o), 32'(1) << e.idx);
                        check("done_no_err", 32'(err_o), 0);
                        check("burst_ticks", 32'(ticks), 32'(e.burst));
                        if (e.burst == 0) begin
                            check("zero_latency", 32'(cyc - e.gcyc), 2);
                            check("zero_no_en", 32'(en_seen), 0);
                        end else begin
                            check("tick_to_done", 32'(cyc - last_tick_cyc), 1);
                        end
                    end
                    $display("burst end req %0d ticks %0d done %b err %b", e.idx, ticks, done_o, err_o);
                    model_rr = (e.idx + 1) % NUM_REQ;
                end
                n_done++;
            end
            if (req_ready_o != '0) begin
                pick = -1;
                for (int i = 0; i < NUM_REQ; i++)
                    if (pick < 0 && req_valid_i[(model_rr + i) % NUM_REQ]) pick = (model_rr + i) % NUM_REQ;
                check("grant", 32'(req_ready_o), (pick < 0) ? 32'(0) : (32'(1) << pick));
                if (pick >= 0) begin
                    e.idx = pick; e.burst = burst_tb[pick]; e.prsc = prsc_tb[pick];
                    e.gcyc = cyc; e.exp_err = tick_block;
                    sb_q.push_back(e);
                    grant_log.push_back(pick);
                    $display("grant req %0d prsc %0d burst %0d", pick, e.prsc, e.burst);
                end
                ticks   = 0;
                en_seen = 1'b0;
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n_done < target) check("wait_done_timeout", 32'(n_done), 32'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready_o), 0);
        check({tag, "_done"},  32'(done_o), 0);
        check({tag, "_err"},   32'(err_o), 0);
        check({tag, "_en"},    32'(prsc_en_o), 0);
        check({tag, "_count"}, 32'(prsc_count_o), 0);
        check({tag, "_busy"},  32'(busy_o), 0);
        check({tag, "_owner"}, 32'(owner_o), 0);
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n;
        prsc_tb  = '{2, 0, 5, 1};
        burst_tb = '{5, 3, 0, 2};
        req_valid_i = 4'b1111;
        repeat (3) @(posedge clk_i);
        #1 check_idle_outputs("reset");

        // Round robin with all valids held; req2 exercises a zero-length burst.
        @(posedge clk_i); #1 rstn_i = 1'b1;
        @(negedge clk_i); #1 check("first_grant", 32'(req_ready_o), 32'b0001);
        wait_done(5, 400);
        req_valid_i = '0;
        check("rr_count", 32'(grant_log.size()), 5);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) check("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));

        // Single request on req0 with the prescaler ticking every 3 clocks.
        repeat (2) @(posedge clk_i); #1;
        req_valid_i = 4'b0001;
        wait_done(6, 200);
        req_valid_i = '0;
        @(negedge clk_i); #1 check("busy_drop", 32'(busy_o), 0);

        // Mid-burst reset on a 10-tick burst.
        burst_tb[1] = 10;
        prsc_tb[1]  = 1;
        @(posedge clk_i); #1 req_valid_i = 4'b0010;
        n = 0;
        while (ticks < 4 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("mid_ticks_reached", 32'(ticks >= 4), 1);
        @(negedge clk_i); #2 rstn_i = 1'b0;
        #1 check_idle_outputs("mid_reset");
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        wait_done(7, 200);
        req_valid_i = '0;
        check("after_reset_owner", 32'(owner_o), 1);

`ifdef PRSC_SCHED_TIMEOUT_EN
        // Ticks suppressed: both req2 and req3 hit the watchdog in turn.
        burst_tb[2] = 3;
        tick_block  = 1'b1;
        repeat (2) @(posedge clk_i); #1;
        req_valid_i = 4'b1100;
        wait_done(9, 200);
        req_valid_i = '0;
        tick_block  = 1'b0;
`endif

        repeat (3) @(posedge clk_i);
        #1 check("final_queue_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
